// File: rtl/sd_cmd_phy.sv
// sd_cmd_phy: SD host CMD-line PHY; sends 48-bit command tokens and receives 48/136-bit responses.
// Optional macro SD_CMD_PHY_CRC_CHECK_EN enables response CRC7 checking (crc_error is 0 otherwise).
module sd_cmd_phy #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         strobe_in,
    input  logic [39:0]  cmd_in,
    input  logic         ack_in,
    input  logic         cmd_pin_in,
    output logic         cmd_pin_out,
    output logic         cmd_oe,
    output logic         strobe_out,
    output logic         ack_out,
    output logic [135:0] response,
    output logic         timeout,
    output logic         crc_error
);
    typedef enum logic [2:0] {IDLE, TX, WAIT_RESP, RX, RESP_VALID, DONE} state_t;
    typedef enum logic [1:0] {RESP_NONE, RESP_SHORT, RESP_R3, RESP_LONG} resp_kind_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state;
    state_t             next_state;
    resp_kind_t         resp_kind;
    logic               strobe_prev;
    logic [47:0]        tx_shift;
    logic [7:0]         bit_cnt;
    logic [CNT_W-1:0]   wait_cnt;
    logic               start_edge;
    logic               abort;
    logic               tx_last;
    logic               rx_last;
    logic               wait_expire;
    logic [135:0]       rx_frame;
    logic               rx_crc_bad;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] data);
        logic [6:0] crc;
        crc = '0;
        for (int i = 39; i >= 0; i--) crc = crc7_step(crc, data[i]);
        return crc;
    endfunction

    function automatic resp_kind_t classify(input logic [5:0] idx);
        case (idx)
            6'd0, 6'd4, 6'd15: return RESP_NONE;
            6'd2, 6'd9, 6'd10: return RESP_LONG;
            6'd41:             return RESP_R3;
            default:           return RESP_SHORT;
        endcase
    endfunction

    assign start_edge  = strobe_in & ~strobe_prev;
    assign abort       = ~strobe_in;
    assign tx_last     = (bit_cnt == 8'd47);
    assign rx_last     = (resp_kind == RESP_LONG) ? (bit_cnt == 8'd135) : (bit_cnt == 8'd47);
    assign wait_expire = cmd_pin_in && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rx_frame    = {response[134:0], cmd_pin_in};

`ifdef SD_CMD_PHY_CRC_CHECK_EN
    function automatic logic [6:0] crc7_120(input logic [119:0] data);
        logic [6:0] crc;
        crc = '0;
        for (int i = 119; i >= 0; i--) crc = crc7_step(crc, data[i]);
        return crc;
    endfunction

    // Long responses exclude the start/transmit/reserved byte; R3 carries no valid CRC.
    always_comb begin
        rx_crc_bad = 1'b0;
        case (resp_kind)
            RESP_LONG:  rx_crc_bad = (crc7_120(rx_frame[127:8]) != rx_frame[7:1]);
            RESP_SHORT: rx_crc_bad = (crc7_40(rx_frame[47:8]) != rx_frame[7:1]);
            default:    rx_crc_bad = 1'b0;
        endcase
    end
`else
    assign rx_crc_bad = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // A low strobe_in during an active phase means the controller gave up; abort wins over everything.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (start_edge) next_state = TX;
            TX: begin
                if (abort)        next_state = IDLE;
                else if (tx_last) next_state = (resp_kind == RESP_NONE) ? RESP_VALID : WAIT_RESP;
            end
            WAIT_RESP: begin
                if (abort)            next_state = IDLE;
                else if (!cmd_pin_in) next_state = RX;
                else if (wait_expire) next_state = IDLE;
            end
            RX: begin
                if (abort)        next_state = IDLE;
                else if (rx_last) next_state = RESP_VALID;
            end
            RESP_VALID: if (ack_in) next_state = DONE;
            DONE:       next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_oe      = (state == TX);
        cmd_pin_out = (state == TX) ? tx_shift[47] : 1'b1;
        strobe_out  = (state == RESP_VALID);
        ack_out     = (state == DONE);
    end

    // strobe_prev resets high so a strobe already asserted across reset release is not taken as a new command.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            strobe_prev <= 1'b1;
            tx_shift    <= '0;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
            resp_kind   <= RESP_NONE;
            response    <= '0;
            timeout     <= 1'b0;
            crc_error   <= 1'b0;
        end else begin
            strobe_prev <= strobe_in;
            timeout     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        tx_shift  <= {cmd_in, crc7_40(cmd_in), 1'b1};
                        bit_cnt   <= '0;
                        resp_kind <= classify(cmd_in[37:32]);
                        response  <= '0;
                        crc_error <= 1'b0;
                    end
                end
                TX: begin
                    tx_shift <= {tx_shift[46:0], 1'b1};
                    bit_cnt  <= bit_cnt + 8'd1;
                    wait_cnt <= '0;
                end
                WAIT_RESP: begin
                    if (!abort) begin
                        if (!cmd_pin_in) begin
                            response <= rx_frame;
                            bit_cnt  <= 8'd1;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                            timeout  <= wait_expire;
                        end
                    end
                end
                RX: begin
                    response <= rx_frame;
                    bit_cnt  <= bit_cnt + 8'd1;
                    if (rx_last) crc_error <= rx_crc_bad;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_phy.sv
// Testbench for sd_cmd_phy: randomized transactions checked every cycle against a timeline model.
module tb_sd_cmd_phy;
    localparam int TIMEOUT = 64;
`ifdef SD_CMD_PHY_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         strobe_in = 1'b0;
    logic [39:0]  cmd_in = '0;
    logic         ack_in = 1'b0;
    logic         cmd_pin_in = 1'b1;
    logic         cmd_pin_out;
    logic         cmd_oe;
    logic         strobe_out;
    logic         ack_out;
    logic [135:0] response;
    logic         timeout;
    logic         crc_error;

    sd_cmd_phy #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .strobe_in(strobe_in), .cmd_in(cmd_in),
        .ack_in(ack_in), .cmd_pin_in(cmd_pin_in), .cmd_pin_out(cmd_pin_out),
        .cmd_oe(cmd_oe), .strobe_out(strobe_out), .ack_out(ack_out),
        .response(response), .timeout(timeout), .crc_error(crc_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    logic         exp_valid = 1'b0;
    logic         exp_oe = 1'b0, exp_pin = 1'b1, exp_sv = 1'b0, exp_ack = 1'b0, exp_to = 1'b0;
    logic         exp_resp_chk = 1'b0, exp_crc = 1'b0;
    logic [135:0] exp_resp = '0;

    task automatic check_bit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0b expected=%0b t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [135:0] actual, input logic [135:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, actual, expected, $time);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1, over bits hi..lo of v.
    function automatic logic [6:0] ref_crc7(input logic [135:0] v, input int hi, input int lo);
        logic [142:0] work;
        int n;
        n = hi - lo + 1;
        work = {7'b0, v} >> lo;
        work = work & ((143'd1 << n) - 143'd1);
        work = work << 7;
        for (int b = n + 6; b >= 7; b--)
            if (work[b]) work[b -: 8] = work[b -: 8] ^ 8'h89;
        return work[6:0];
    endfunction

    function automatic int resp_len(input logic [5:0] idx);
        if (idx == 6'd0 || idx == 6'd4 || idx == 6'd15) return 0;
        if (idx == 6'd2 || idx == 6'd9 || idx == 6'd10) return 136;
        return 48;
    endfunction

    function automatic logic [135:0] make_frame(input int len, input logic [5:0] idx, input logic corrupt);
        logic [135:0] f;
        f = '0;
        if (len == 48) begin
            f[47:8] = {2'b00, idx, 32'($urandom())};
            f[7:1]  = ref_crc7(f, 47, 8);
        end else begin
            f[135:128] = 8'h3F;
            f[127:8]   = {32'($urandom()), 32'($urandom()), 32'($urandom()), 24'($urandom())};
            f[7:1]     = ref_crc7(f, 127, 8);
        end
        f[0] = 1'b1;
        if (corrupt) f[7:1] = f[7:1] ^ (7'd1 << $urandom_range(0, 6));
        return f;
    endfunction

    function automatic logic exp_crc_err(input int len, input logic [5:0] idx, input logic [135:0] f);
        logic bad;
        bad = 1'b0;
        if (len == 136)                bad = (ref_crc7(f, 127, 8) != f[7:1]);
        else if (len == 48 && idx != 6'd41) bad = (ref_crc7(f, 47, 8) != f[7:1]);
        return CRC_EN && bad;
    endfunction

    // Compare process: every cycle the model marks valid, all outputs are checked mid-cycle.
    always @(negedge clock) begin
        if (exp_valid) begin
            check_bit("cmd_oe", cmd_oe, exp_oe);
            check_bit("cmd_pin_out", cmd_pin_out, exp_pin);
            check_bit("strobe_out", strobe_out, exp_sv);
            check_bit("ack_out", ack_out, exp_ack);
            check_bit("timeout", timeout, exp_to);
            if (exp_resp_chk) begin
                check_vec("response", response, exp_resp);
                check_bit("crc_error", crc_error, exp_crc);
            end
        end
    end

    task automatic set_idle_expect();
        exp_oe = 1'b0; exp_pin = 1'b1; exp_sv = 1'b0; exp_ack = 1'b0; exp_to = 1'b0;
        exp_resp_chk = 1'b0;
    endtask

    // Cycle t=0 raises strobe_in; the model derives every output of cycle t from the protocol timeline.
    task automatic applyStimulus(input logic [39:0] cmd, input int resp_delay, input logic corrupt,
                                 input int ack_delay, input int abort_at, input int reset_at,
                                 input logic use_frame, input logic [135:0] frame_in,
                                 output logic [47:0] tx_seen, output logic [135:0] resp_seen,
                                 output logic crc_seen);
        int len, t_start, t_sv, t_done, t_to, t_end;
        logic [47:0] token;
        logic [135:0] frame;
        logic timed_out, aborted, crc_exp;
        len = resp_len(cmd[37:32]);
        token = {cmd, ref_crc7({96'b0, cmd}, 39, 0), 1'b1};
        frame = (len == 0) ? '0 : (use_frame ? frame_in : make_frame(len, cmd[37:32], corrupt));
        crc_exp = (len == 0) ? 1'b0 : exp_crc_err(len, cmd[37:32], frame);
        timed_out = (len != 0) && (resp_delay >= TIMEOUT);
        t_start = 49 + resp_delay;
        t_sv = (len == 0) ? 49 : t_start + len;
        t_done = t_sv + ((ack_delay < 0) ? 0 : ack_delay) + 1;
        t_to = 49 + TIMEOUT;
        t_end = timed_out ? t_to : t_done + 1;
        if (abort_at > 0) t_end = abort_at + 1;
        tx_seen = '0;
        resp_seen = '0;
        crc_seen = 1'b0;
        for (int t = 0; t <= t_end + 1; t++) begin
            @(posedge clock);
            #1;
            aborted = (abort_at > 0) && (t > abort_at);
            strobe_in = (t < t_end) && !((abort_at > 0) && (t >= abort_at));
            cmd_in = cmd;
            ack_in = (t >= t_sv + ack_delay) && (t < t_end);
            cmd_pin_in = (!timed_out && !aborted && len != 0 && t >= t_start && t < t_start + len)
                         ? frame[len - 1 - (t - t_start)] : 1'b1;
            exp_oe = !aborted && (t >= 1) && (t <= 48);
            exp_pin = exp_oe ? token[48 - t] : 1'b1;
            exp_sv = !aborted && !timed_out && (t >= t_sv) && (t < t_done);
            exp_ack = !aborted && !timed_out && (t == t_done);
            exp_to = !aborted && timed_out && (t == t_to);
            exp_resp_chk = exp_sv || exp_ack;
            exp_resp = frame;
            exp_crc = crc_exp;
            exp_valid = 1'b1;
            if (t >= 1 && t <= 48) tx_seen[48 - t] = cmd_pin_out;
            if (exp_sv && t == t_sv) begin
                resp_seen = response;
                crc_seen = crc_error;
            end
            if (reset_at > 0 && t == reset_at) begin
                exp_valid = 1'b0;
                #2 reset = 1'b0;
                #1;
                check_bit("rst_cmd_oe", cmd_oe, 1'b0);
                check_bit("rst_cmd_pin_out", cmd_pin_out, 1'b1);
                check_bit("rst_strobe_out", strobe_out, 1'b0);
                check_bit("rst_ack_out", ack_out, 1'b0);
                check_bit("rst_timeout", timeout, 1'b0);
                check_vec("rst_response", response, '0);
                strobe_in = 1'b0;
                ack_in = 1'b0;
                cmd_pin_in = 1'b1;
                repeat (2) @(posedge clock);
                #1 reset = 1'b1;
                @(posedge clock);
                #1;
                set_idle_expect();
                exp_valid = 1'b1;
                return;
            end
        end
        ack_in = 1'b0;
        set_idle_expect();
    endtask

    task automatic checkOutput(input string name, input logic [135:0] actual, input logic [135:0] expected);
        check_vec(name, actual, expected);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [47:0]  tx;
        logic [135:0] rs;
        logic         ce;
        logic [5:0]   idx_pool [10] = '{6'd0, 6'd2, 6'd8, 6'd17, 6'd41, 6'd9, 6'd55, 6'd4, 6'd10, 6'd13};
        $display("[TB] sd_cmd_phy bench start, CRC check %0s", CRC_EN ? "enabled" : "disabled");
        repeat (3) @(posedge clock);
        #1;
        check_bit("reset_cmd_oe", cmd_oe, 1'b0);
        check_bit("reset_cmd_pin_out", cmd_pin_out, 1'b1);
        check_bit("reset_strobe_out", strobe_out, 1'b0);
        check_bit("reset_crc_error", crc_error, 1'b0);
        checkOutput("reset_response", response, '0);
        reset = 1'b1;
        set_idle_expect();
        exp_valid = 1'b1;
        repeat (2) @(posedge clock);

        applyStimulus(40'h40_0000_0000, 0, 1'b0, 1, 0, 0, 1'b0, '0, tx, rs, ce);
        checkOutput("cmd0_token", {88'b0, tx}, {88'b0, 48'h40_0000_0000_95});
        checkOutput("cmd0_response", rs, '0);

        applyStimulus(40'h48_0000_01AA, 3, 1'b0, 2, 0, 0, 1'b1, {88'b0, 48'h08_0000_01AA_13}, tx, rs, ce);
        checkOutput("cmd8_token", {88'b0, tx}, {88'b0, 48'h48_0000_01AA_87});
        checkOutput("cmd8_response", rs, {88'b0, 48'h08_0000_01AA_13});
        check_bit("cmd8_crc_ok", ce, 1'b0);

        applyStimulus(40'h48_0000_01AA, 0, 1'b0, -3, 0, 0, 1'b1, {88'b0, 48'h08_0000_01AA_15}, tx, rs, ce);
        check_bit("cmd8_crc_bad", ce, CRC_EN);

        applyStimulus({2'b01, 6'd2, 32'h0}, 5, 1'b0, 0, 0, 0, 1'b0, '0, tx, rs, ce);
        checkOutput("cmd2_first_byte", {128'b0, rs[135:128]}, {128'b0, 8'h3F});

        applyStimulus({2'b01, 6'd17, 32'h1234}, TIMEOUT, 1'b0, 0, 0, 0, 1'b0, '0, tx, rs, ce);
        applyStimulus({2'b01, 6'd17, 32'h5678}, TIMEOUT - 1, 1'b0, 0, 0, 0, 1'b0, '0, tx, rs, ce);
        applyStimulus({2'b01, 6'd41, 32'h0}, 1, 1'b1, 0, 0, 0, 1'b0, '0, tx, rs, ce);
        check_bit("r3_no_crc_check", ce, 1'b0);

        applyStimulus({2'b01, 6'd17, 32'hDEAD}, 0, 1'b0, 0, 0, 21, 1'b0, '0, tx, rs, ce);
        applyStimulus(40'h48_0000_01AA, 2, 1'b0, 0, 0, 0, 1'b0, '0, tx, rs, ce);
        checkOutput("post_reset_token", {88'b0, tx}, {88'b0, 48'h48_0000_01AA_87});

        applyStimulus({2'b01, 6'd8, 32'h1}, 0, 1'b0, 0, 20, 0, 1'b0, '0, tx, rs, ce);
        applyStimulus({2'b01, 6'd8, 32'h2}, 30, 1'b0, 0, 60, 0, 1'b0, '0, tx, rs, ce);
        applyStimulus({2'b01, 6'd8, 32'h3}, 20, 1'b0, 0, TIMEOUT + 48, 0, 1'b0, '0, tx, rs, ce);
        applyStimulus({2'b01, 6'd9, 32'h4}, 2, 1'b0, 0, 120, 0, 1'b0, '0, tx, rs, ce);

        for (int n = 0; n < 30; n++) begin
            logic [5:0] idx;
            int len, d, lim, ab;
            idx = idx_pool[$urandom_range(0, 9)];
            len = resp_len(idx);
            d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2))
                                            : int'($urandom_range(0, 15));
            if (len == 0)           lim = 48;
            else if (d >= TIMEOUT)  lim = 48 + TIMEOUT;
            else                    lim = 48 + d + len;
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, lim)) : 0;
            applyStimulus({2'b01, idx, 32'($urandom())}, d, ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 5)) - 1, ab, 0, 1'b0, '0, tx, rs, ce);
            repeat ($urandom_range(0, 2)) @(posedge clock);
        end

        exp_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
